// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue sequencer for the tiny 8-bit datapath. It accepts one instruction per
//   valid/ready handshake. It reads its operands from a small internal register
//   file or takes an immediate. It then presents the operation and operands to
//   the external combinational ALU for one cycle. Finally it commits the ALU
//   result and flags back into the register file.
//
//   Flow:  IDLE --valid&legal--> EXEC --> DONE --> IDLE
//          IDLE --valid&illegal--> ERR --> IDLE
//
//   Optional feature macro: ALU_ISSUE_PERF_EN
//     defined     : perf_count counts committed instructions (wraps at 16 bits)
//     not defined : perf_count is tied to zero and no counter logic is built
//
//   Reset is synchronous and active-high. It returns every piece of state to
//   its idle value, including the register file.
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int NUM_REGS   = 4,
  parameter int REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,

  // Instruction front-end
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic [REG_ADDR_W-1:0] instr_rs1,
  input  logic [REG_ADDR_W-1:0] instr_rs2,
  input  logic                  instr_use_imm,
  input  logic [7:0]            instr_imm,

  // Combinational ALU
  output logic [3:0]            alu_operation,
  output logic [7:0]            alu_operand1,
  output logic [7:0]            alu_operand2,
  input  logic [7:0]            alu_result,
  input  logic                  alu_zero_flag,
  input  logic                  alu_overflow_flag,

  // Status
  output logic                  done,
  output logic                  illegal_op,
  output logic                  zero_q,
  output logic                  overflow_q,

  // Debug / performance
  input  logic [REG_ADDR_W-1:0] rf_dbg_addr,
  output logic [7:0]            rf_dbg_data,
  output logic [15:0]           perf_count
);

  // ---------------------------------------------------------------------------
  // Opcode map understood by the ALU
  // ---------------------------------------------------------------------------
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b1101;
  localparam logic [3:0] OP_SHR  = 4'b1110;

  // The ALU sees this code whenever no instruction is executing. Its output is
  // ignored in that case.
  localparam logic [3:0] OP_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // Legality decode of an incoming opcode
  function automatic logic op_is_legal(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR: op_is_legal = 1'b1;
      default:                op_is_legal = 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;

  logic [3:0]              op_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [7:0]              opnd1_q;
  logic [7:0]              opnd2_q;
  logic [7:0]              rf_q [NUM_REGS];

  logic                    accept;
  logic                    wb_en;
  logic [7:0]              opnd1_d;
  logic [7:0]              opnd2_d;

  // A handshake happens only in IDLE, because ready is high only there.
  assign accept = instr_valid & instr_ready;

  // The writeback happens on the edge that leaves EXEC.
  assign wb_en  = (state_q == ST_EXEC);

  // Operand fetch from the register file, or the immediate for operand2
  assign opnd1_d = rf_q[instr_rs1];
  assign opnd2_d = instr_use_imm ? instr_imm : rf_q[instr_rs2];

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default in always_comb infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = op_is_legal(instr_op) ? ST_EXEC : ST_ERR;
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_ready   = 1'b0;
    done          = 1'b0;
    illegal_op    = 1'b0;
    alu_operation = OP_IDLE;
    case (state_q)
      ST_IDLE: instr_ready   = 1'b1;
      ST_EXEC: alu_operation = op_q;
      ST_DONE: done          = 1'b1;
      ST_ERR:  illegal_op    = 1'b1;
      default: ;
    endcase
  end

  // The operands always show the latched values. They only matter in EXEC.
  assign alu_operand1 = opnd1_q;
  assign alu_operand2 = opnd2_q;

  // ---------------------------------------------------------------------------
  // Instruction latch: op, destination and operand values are captured at accept
  // ---------------------------------------------------------------------------
  // The operands are latched for illegal opcodes too. This is harmless: the ALU
  // never sees them with a real operation code, and they stay stable until the
  // next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      rd_q    <= '0;
      opnd1_q <= '0;
      opnd2_q <= '0;
    end else if (accept) begin
      op_q    <= instr_op;
      rd_q    <= instr_rd;
      opnd1_q <= opnd1_d;
      opnd2_q <= opnd2_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file writeback
  // ---------------------------------------------------------------------------
  // NOTE: the register file must come out of reset as all zeros, so every
  // entry is cleared explicitly. This maps the array onto resettable flops
  // rather than a RAM macro, which is fine at four entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[rd_q] <= alu_result;
    end
  end

  // ---------------------------------------------------------------------------
  // Flag capture: only legal instructions reach EXEC, so only they update flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (wb_en) begin
      zero_q     <= alu_zero_flag;
      overflow_q <= alu_overflow_flag;
    end
  end

  // Debug read port. There is no hazard logic, because the writeback lands
  // before the controller returns to IDLE.
  assign rf_dbg_data = rf_q[rf_dbg_addr];

  // ---------------------------------------------------------------------------
  // Optional performance counter
  // ---------------------------------------------------------------------------
`ifdef ALU_ISSUE_PERF_EN
  logic [15:0] perf_q;

  // Count each committed instruction. The count wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)       perf_q <= '0;
    else if (done) perf_q <= perf_q + 16'd1;
  end

  assign perf_count = perf_q;
`else
  assign perf_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. A behavioural model of the 8-bit ALU
//   answers the controller's operation/operand ports. A shadow register file
//   predicts each result, and the prediction is pushed to a scoreboard queue
//   when the instruction is issued. The entry is popped and compared when the
//   done pulse appears. Define ALU_ISSUE_PERF_EN to check the counter as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [1:0]  instr_rd, instr_rs1, instr_rs2;
  logic        instr_use_imm;
  logic [7:0]  instr_imm;
  logic [3:0]  alu_operation;
  logic [7:0]  alu_operand1, alu_operand2, alu_result;
  logic        alu_zero_flag, alu_overflow_flag;
  logic        done, illegal_op, zero_q, overflow_q;
  logic [1:0]  rf_dbg_addr;
  logic [7:0]  rf_dbg_data;
  logic [15:0] perf_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic       zero;
    logic       ovf;
  } sb_entry_t;

  sb_entry_t  sb_q[$];
  logic [7:0] shadow_rf [4];
  logic       shadow_zero, shadow_ovf;
  int         perf_model;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.NUM_REGS(4), .REG_ADDR_W(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_op          (instr_op),
    .instr_rd          (instr_rd),
    .instr_rs1         (instr_rs1),
    .instr_rs2         (instr_rs2),
    .instr_use_imm     (instr_use_imm),
    .instr_imm         (instr_imm),
    .alu_operation     (alu_operation),
    .alu_operand1      (alu_operand1),
    .alu_operand2      (alu_operand2),
    .alu_result        (alu_result),
    .alu_zero_flag     (alu_zero_flag),
    .alu_overflow_flag (alu_overflow_flag),
    .done              (done),
    .illegal_op        (illegal_op),
    .zero_q            (zero_q),
    .overflow_q        (overflow_q),
    .rf_dbg_addr       (rf_dbg_addr),
    .rf_dbg_data       (rf_dbg_data),
    .perf_count        (perf_count)
  );

  // Behavioural ALU. Returns {overflow, zero, result[7:0]}.
  function automatic logic [9:0] alu_model(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    logic [8:0] wide;
    logic [7:0] r;
    logic       c;
    wide = 9'd0;
    r    = 8'd0;
    c    = 1'b0;
    case (op)
      4'b0000: begin wide = {1'b0, a} + {1'b0, b}; r = wide[7:0]; c = wide[8]; end
      4'b0010: begin r = a - b; c = (a < b); end
      4'b0011: r = a & b;
      4'b0100: r = a | b;
      4'b0101: r = a ^ b;
      4'b1101: r = (b[3:0] >= 4'd8) ? 8'h00 : (a << b[3:0]);
      4'b1110: r = (b[3:0] >= 4'd8) ? 8'h00 : (a >> b[3:0]);
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  always_comb begin
    {alu_overflow_flag, alu_zero_flag, alu_result} =
      alu_model(alu_operation, alu_operand1, alu_operand2);
  end

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b1101, 4'b1110};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] perf_expect();
`ifdef ALU_ISSUE_PERF_EN
    return 16'(perf_model);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic read_rf(input logic [1:0] idx, output logic [7:0] val);
    rf_dbg_addr = idx;
    #1;
    val = rf_dbg_data;
  endtask

  // Issue one instruction and follow it to completion.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic use_imm, input logic [7:0] imm);
    logic [7:0] exp_a, exp_b, got;
    logic [9:0] res;
    sb_entry_t  e;
    int         lat;
    bit         legal;

    legal = legal_op(op);
    @(negedge clk);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_rs1 = rs1;
    instr_rs2 = rs2; instr_use_imm = use_imm; instr_imm = imm;
    check("ready_in_idle", 16'(instr_ready), 16'h1);
    exp_a = shadow_rf[rs1];
    exp_b = use_imm ? imm : shadow_rf[rs2];
    if (legal) begin
      res = alu_model(op, exp_a, exp_b);
      sb_q.push_back('{rd: rd, data: res[7:0], zero: res[8], ovf: res[9]});
    end
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("ready_low_after_accept", 16'(instr_ready), 16'h0);
    if (legal) begin
      check("exec_alu_op", 16'(alu_operation), 16'(op));
      check("exec_operand1", 16'(alu_operand1), 16'(exp_a));
      check("exec_operand2", 16'(alu_operand2), 16'(exp_b));
      check("exec_no_illegal", 16'(illegal_op), 16'h0);
      lat = 1;
      while (done !== 1'b1 && lat < 6) begin
        @(negedge clk);
        lat++;
      end
      check("done_latency", 16'(lat), 16'd2);
      check("ready_low_in_done", 16'(instr_ready), 16'h0);
      if (sb_q.size() == 0) begin
        check("sb_underflow", 16'h1, 16'h0);
      end else begin
        e = sb_q.pop_front();
        read_rf(e.rd, got);
        check("wb_data", 16'(got), 16'(e.data));
        check("zero_q", 16'(zero_q), 16'(e.zero));
        check("overflow_q", 16'(overflow_q), 16'(e.ovf));
        shadow_rf[e.rd] = e.data;
        shadow_zero     = e.zero;
        shadow_ovf      = e.ovf;
        perf_model++;
      end
      @(negedge clk);
      check("done_one_cycle", 16'(done), 16'h0);
    end else begin
      check("illegal_pulse", 16'(illegal_op), 16'h1);
      check("illegal_no_done", 16'(done), 16'h0);
      @(negedge clk);
      check("illegal_one_cycle", 16'(illegal_op), 16'h0);
      check("illegal_no_done_2", 16'(done), 16'h0);
      read_rf(rd, got);
      check("illegal_rf_kept", 16'(got), 16'(shadow_rf[rd]));
      check("illegal_zero_kept", 16'(zero_q), 16'(shadow_zero));
      check("illegal_ovf_kept", 16'(overflow_q), 16'(shadow_ovf));
    end
    check("ready_back_idle", 16'(instr_ready), 16'h1);
    check("perf_count", perf_count, perf_expect());
  endtask

  task automatic reset_model();
    for (int i = 0; i < 4; i++) shadow_rf[i] = 8'h00;
    shadow_zero = 1'b0;
    shadow_ovf  = 1'b0;
    perf_model  = 0;
  endtask

  task automatic check_reset_state(input string tag);
    logic [7:0] got;
    check({tag, "_ready"}, 16'(instr_ready), 16'h1);
    check({tag, "_done"}, 16'(done), 16'h0);
    check({tag, "_illegal"}, 16'(illegal_op), 16'h0);
    check({tag, "_zero_q"}, 16'(zero_q), 16'h0);
    check({tag, "_ovf_q"}, 16'(overflow_q), 16'h0);
    check({tag, "_alu_op"}, 16'(alu_operation), 16'hF);
    check({tag, "_opnd1"}, 16'(alu_operand1), 16'h0);
    check({tag, "_opnd2"}, 16'(alu_operand2), 16'h0);
    check({tag, "_perf"}, perf_count, 16'h0);
    for (int i = 0; i < 4; i++) begin
      read_rf(2'(i), got);
      check({tag, "_rf"}, 16'(got), 16'h0);
    end
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr_op = '0; instr_rd = '0; instr_rs1 = '0;
    instr_rs2 = '0; instr_use_imm = 1'b0; instr_imm = '0; rf_dbg_addr = '0;
    reset_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset");

    // Basic add, then an add that wraps to zero with a carry
    issue(4'b0000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F);
    issue(4'b0000, 2'd2, 2'd1, 2'd0, 1'b1, 8'h81);
    // Subtract with borrow, then self-XOR giving zero
    issue(4'b0010, 2'd3, 2'd0, 2'd0, 1'b1, 8'h01);
    issue(4'b0101, 2'd3, 2'd3, 2'd3, 1'b0, 8'h00);
    // Logic ops with register operands
    issue(4'b0100, 2'd0, 2'd1, 2'd3, 1'b0, 8'h00);
    issue(4'b0011, 2'd2, 2'd1, 2'd0, 1'b1, 8'h3C);
    // Shifts: in-range right shift, out-of-range left shift
    issue(4'b1110, 2'd1, 2'd1, 2'd0, 1'b1, 8'h03);
    issue(4'b1101, 2'd1, 2'd1, 2'd0, 1'b1, 8'h09);
    // Illegal opcodes leave state untouched
    issue(4'b0001, 2'd2, 2'd0, 2'd0, 1'b1, 8'hAA);
    issue(4'b1111, 2'd0, 2'd0, 2'd0, 1'b1, 8'h55);

    // Reset during EXEC: the writeback must be dropped
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'b0000; instr_rd = 2'd0; instr_rs1 = 2'd2;
    instr_use_imm = 1'b1; instr_imm = 8'h55;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    check("mid_exec_op", 16'(alu_operation), 16'h0);
    rst = 1'b1;
    reset_model();
    @(posedge clk);
    @(negedge clk);
    check("rst_no_done", 16'(done), 16'h0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid_exec_reset");

    // Three legal and one illegal instruction after reset
    issue(4'b0000, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10);
    issue(4'b0111, 2'd1, 2'd1, 2'd0, 1'b1, 8'h01);
    issue(4'b0010, 2'd2, 2'd1, 2'd0, 1'b1, 8'h20);
    issue(4'b0100, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
    check("perf_after_four", perf_count, perf_expect());
    check("sb_empty", 16'(sb_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: bound the whole run
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog timeout");
  end

endmodule
